pe_mem_wr_ctrl: RTL and testbench
=================================

PE_MEM_WR_CTRL -- requirements
Module: pe_mem_wr_ctrl

Interface
REQ-001 SHALL have parameter peId, default 0: lane ID this PE answers to.
REQ-002 SHALL have parameter logNumPeMemLanes, default 2: width of peId_mem_in.
REQ-003 SHALL have parameter memDataLen, default 16: memory word width.
REQ-004 SHALL have parameter logMemNamespaces, default 2: width of mem_data_type.
REQ-005 SHALL have parameters instAddrLen, dataAddrLen, weightAddrLen, metaAddrLen, default 8 each: per-namespace address widths; depth = 2^len.
REQ-006 SHALL have ports in this order: clk in 1, the single clock; reset in 1, asynchronous, active-high.
REQ-007 start in 1: program loaded, begin execution.
REQ-008 eoc in 1: end of computation.
REQ-009 mem_wrt_valid in 1: memory write strobe.
REQ-010 peId_mem_in in logNumPeMemLanes: target PE lane.
REQ-011 mem_data_type in logMemNamespaces: namespace (0 inst, 1 data, 2 weight, 3 meta).
REQ-012 mem_data_input in memDataLen: write data.
REQ-013 inst_wr_en/data_wr_en/weight_wr_en/meta_wr_en out 1 each: one-hot write strobe to the PE memories.
REQ-014 inst_wr_addr/data_wr_addr/weight_wr_addr/meta_wr_addr out *AddrLen each: write address.
REQ-015 wr_data out memDataLen: registered write data.
REQ-016 loading out 1: high in LOAD state; running out 1: high in RUN state.
REQ-017 err_wr_in_run out 1, err_overflow out 1: sticky error flags.

Function
REQ-018 Write SHALL be accepted when mem_wrt_valid=1, peId_mem_in==peId[logNumPeMemLanes-1:0] and state is IDLE or LOAD.
REQ-019 Accepted write SHALL assert exactly one *_wr_en, drive its counter value as *_wr_addr, and drive wr_data, all registered, 1 cycle after acceptance.
REQ-020 Each namespace SHALL own an address counter starting at 0, incrementing by 1 per accepted write to that namespace only.
REQ-021 *_wr_en SHALL be 0 in every cycle without an accepted write; addresses and wr_data hold last values.
REQ-022 FSM states: IDLE, LOAD, RUN. IDLE->LOAD on accepted write; IDLE->RUN on start; LOAD->RUN on start; RUN->IDLE on eoc; otherwise hold.
REQ-023 start and an accepted write in the same LOAD cycle: write completes normally, state moves to RUN.
REQ-024 start and eoc in the same RUN cycle: eoc wins, next state IDLE; start in RUN alone is ignored.
REQ-025 Write matching peId during RUN SHALL be dropped (no *_wr_en) and SHALL set err_wr_in_run.
REQ-026 On RUN->IDLE all four counters SHALL clear to 0 in the cycle of transition; error flags clear too.
REQ-027 Writes with non-matching peId SHALL be ignored in every state with no side effects.
REQ-028 mem_data_type values above 3 (when logMemNamespaces>2) SHALL be dropped without counter change.

Reset
REQ-029 reset=1 SHALL asynchronously force state IDLE, all counters 0, all *_wr_en 0, all addresses 0, wr_data 0, loading 0, running 0, both error flags 0.
REQ-030 Reset asserted mid-LOAD or mid-RUN SHALL discard all progress; first write after release goes to address 0.

Configuration
REQ-031 Macro PE_MEM_OVF_DETECT_EN defined: a write to a namespace whose counter is at 2^len-1 and already written SHALL be dropped and set err_overflow; counter saturates.
REQ-032 Macro PE_MEM_OVF_DETECT_EN undefined: counters wrap 2^len-1 -> 0 silently, write performed, err_overflow tied to 0.

Structure
REQ-033 Shared package tabla_pe_pkg SHALL hold namespace codes (NS_INST=0, NS_DATA=1, NS_WEIGHT=2, NS_META=3) and the FSM state encoding.
REQ-034 One sub-module pe_ns_addr_cnt (parameterized width, inc, clear, saturate/wrap per macro) SHALL be instantiated four times.

Verification
REQ-035 peId=2; writes lane 2 types 0,0,1 data 0xA,0xB,0xC -> inst_wr_en at addr 0,1 data 0xA,0xB; data_wr_en addr 0 data 0xC; each 1 cycle after input.
REQ-036 Writes to lane 1 while peId=2 -> no *_wr_en, state stays IDLE.
REQ-037 LOAD, start with same-cycle write type 2 -> weight_wr_en addr 0, running=1 next cycle; further write -> dropped, err_wr_in_run=1.
REQ-038 RUN, start+eoc together -> IDLE; next write type 0 goes to addr 0, errors cleared.
REQ-039 instAddrLen=2, 5 inst writes: with macro -> addrs 0..3, 5th dropped, err_overflow=1; without -> addrs 0,1,2,3,0.
REQ-040 Reset pulse mid-LOAD after 3 data writes -> all outputs 0 immediately; next data write at addr 0.

Source files
------------

// File: rtl/tabla_pe_pkg.sv
// ---------------------------------------------------------------------------
// tabla_pe_pkg
// Shared definitions for the PE memory write controller:
//   - namespace codes for mem_data_type (instruction/data/weight/meta)
//   - FSM state encoding for pe_mem_wr_ctrl
// Optional build macro used by the importing files: PE_MEM_OVF_DETECT_EN
// ---------------------------------------------------------------------------
package tabla_pe_pkg;

  localparam int NS_INST   = 0;
  localparam int NS_DATA   = 1;
  localparam int NS_WEIGHT = 2;
  localparam int NS_META   = 3;
  localparam int NUM_NS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } pe_state_e;

endpackage : tabla_pe_pkg

// File: rtl/pe_ns_addr_cnt.sv
// ---------------------------------------------------------------------------
// pe_ns_addr_cnt
// Write-address counter for one PE memory namespace.
// Ports:
//   clk    in  1  clock
//   reset  in  1  asynchronous active-high reset
//   inc    in  1  advance after a write to this namespace
//   clr    in  1  synchronous clear (end of computation)
//   cnt    out W  address for the next write
//   full   out 1  last location already written; further writes must drop
// Macro PE_MEM_OVF_DETECT_EN: defined -> counter saturates at 2^W-1 and
// raises full once that location has been written; undefined -> counter
// wraps silently and full is tied low.
// ---------------------------------------------------------------------------
module pe_ns_addr_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         full
);

  logic [W-1:0] cnt_q;

`ifdef PE_MEM_OVF_DETECT_EN
  localparam logic [W-1:0] CNT_MAX = '1;
  logic full_q;

  // The top location is still writable once; full_q records that it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (inc && !full_q) begin
      if (cnt_q == CNT_MAX) full_q <= 1'b1;
      else                  cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign full = full_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (inc)  cnt_q <= cnt_q + 1'b1;
  end

  assign full = 1'b0;
`endif

  assign cnt = cnt_q;

endmodule : pe_ns_addr_cnt

// File: rtl/pe_mem_wr_ctrl.sv
// ---------------------------------------------------------------------------
// pe_mem_wr_ctrl
// Loads a PE's four memories (inst/data/weight/meta) from a shared write bus
// and tracks the IDLE -> LOAD -> RUN -> IDLE program lifecycle.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, eoc            begin execution / end of computation
//   mem_wrt_valid         write strobe on the shared bus
//   peId_mem_in           target lane; only lane == peId is accepted
//   mem_data_type         namespace select (0 inst,1 data,2 weight,3 meta)
//   mem_data_input        write data
//   *_wr_en, *_wr_addr    registered one-hot strobe and address per memory
//   wr_data               registered write data (holds between writes)
//   loading, running      state indicators
//   err_wr_in_run         sticky: matching write arrived while running
//   err_overflow          sticky: write dropped at a full namespace
// Macro PE_MEM_OVF_DETECT_EN enables overflow drop/flag (else wrap).
// ---------------------------------------------------------------------------
module pe_mem_wr_ctrl
  import tabla_pe_pkg::*;
#(
  parameter int peId             = 0,
  parameter int logNumPeMemLanes = 2,
  parameter int memDataLen       = 16,
  parameter int logMemNamespaces = 2,
  parameter int instAddrLen      = 8,
  parameter int dataAddrLen      = 8,
  parameter int weightAddrLen    = 8,
  parameter int metaAddrLen      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        eoc,
  input  logic                        mem_wrt_valid,
  input  logic [logNumPeMemLanes-1:0] peId_mem_in,
  input  logic [logMemNamespaces-1:0] mem_data_type,
  input  logic [memDataLen-1:0]       mem_data_input,
  output logic                        inst_wr_en,
  output logic                        data_wr_en,
  output logic                        weight_wr_en,
  output logic                        meta_wr_en,
  output logic [instAddrLen-1:0]      inst_wr_addr,
  output logic [dataAddrLen-1:0]      data_wr_addr,
  output logic [weightAddrLen-1:0]    weight_wr_addr,
  output logic [metaAddrLen-1:0]      meta_wr_addr,
  output logic [memDataLen-1:0]       wr_data,
  output logic                        loading,
  output logic                        running,
  output logic                        err_wr_in_run,
  output logic                        err_overflow
);

  localparam logic [logNumPeMemLanes-1:0] PE_LANE = peId[logNumPeMemLanes-1:0];

  pe_state_e state_q, state_d;

  logic [NUM_NS-1:0] ns_sel;   // matching write decoded to a namespace
  logic [NUM_NS-1:0] ns_full;  // namespace cannot take another write
  logic [NUM_NS-1:0] wr_hit;   // write actually performed
  logic              lane_hit;
  logic              can_write;
  logic              type_ok;
  logic              ovf_hit;
  logic              cnt_clr;

  logic [instAddrLen-1:0]   inst_cnt;
  logic [dataAddrLen-1:0]   data_cnt;
  logic [weightAddrLen-1:0] weight_cnt;
  logic [metaAddrLen-1:0]   meta_cnt;

  logic [NUM_NS-1:0]        wr_en_q;
  logic [instAddrLen-1:0]   inst_addr_q;
  logic [dataAddrLen-1:0]   data_addr_q;
  logic [weightAddrLen-1:0] weight_addr_q;
  logic [metaAddrLen-1:0]   meta_addr_q;
  logic [memDataLen-1:0]    wr_data_q;
  logic                     err_run_q;
  logic                     err_ovf_q;

  assign lane_hit  = mem_wrt_valid && (peId_mem_in == PE_LANE);
  assign can_write = lane_hit && (state_q != ST_RUN);
  // Codes above NS_META only exist when the type field is wider than 2 bits.
  assign type_ok   = (int'(mem_data_type) <= NS_META);

  for (genvar gi = 0; gi < NUM_NS; gi++) begin : g_ns_dec
    assign ns_sel[gi] = can_write && type_ok && (int'(mem_data_type) == gi);
  end

  assign wr_hit  = ns_sel & ~ns_full;
  assign ovf_hit = |(ns_sel & ns_full);
  assign cnt_clr = (state_q == ST_RUN) && eoc;

  pe_ns_addr_cnt #(.W(instAddrLen)) u_cnt_inst (
    .clk(clk), .reset(reset), .inc(wr_hit[NS_INST]), .clr(cnt_clr),
    .cnt(inst_cnt), .full(ns_full[NS_INST])
  );
  pe_ns_addr_cnt #(.W(dataAddrLen)) u_cnt_data (
    .clk(clk), .reset(reset), .inc(wr_hit[NS_DATA]), .clr(cnt_clr),
    .cnt(data_cnt), .full(ns_full[NS_DATA])
  );
  pe_ns_addr_cnt #(.W(weightAddrLen)) u_cnt_weight (
    .clk(clk), .reset(reset), .inc(wr_hit[NS_WEIGHT]), .clr(cnt_clr),
    .cnt(weight_cnt), .full(ns_full[NS_WEIGHT])
  );
  pe_ns_addr_cnt #(.W(metaAddrLen)) u_cnt_meta (
    .clk(clk), .reset(reset), .inc(wr_hit[NS_META]), .clr(cnt_clr),
    .cnt(meta_cnt), .full(ns_full[NS_META])
  );

  // Next-state: start dominates a simultaneous write in IDLE/LOAD (the write
  // still completes); eoc dominates start in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start)        state_d = ST_RUN;
        else if (|wr_hit) state_d = ST_LOAD;
      end
      ST_LOAD: if (start) state_d = ST_RUN;
      ST_RUN:  if (eoc)   state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_en_q       <= '0;
      inst_addr_q   <= '0;
      data_addr_q   <= '0;
      weight_addr_q <= '0;
      meta_addr_q   <= '0;
      wr_data_q     <= '0;
      err_run_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_hit;
      if (|wr_hit)             wr_data_q     <= mem_data_input;
      if (wr_hit[NS_INST])     inst_addr_q   <= inst_cnt;
      if (wr_hit[NS_DATA])     data_addr_q   <= data_cnt;
      if (wr_hit[NS_WEIGHT])   weight_addr_q <= weight_cnt;
      if (wr_hit[NS_META])     meta_addr_q   <= meta_cnt;
      // Leaving RUN starts a fresh program, so the sticky flags reset there.
      if (cnt_clr)                                 err_run_q <= 1'b0;
      else if (lane_hit && (state_q == ST_RUN))    err_run_q <= 1'b1;
      if (cnt_clr)      err_ovf_q <= 1'b0;
      else if (ovf_hit) err_ovf_q <= 1'b1;
    end
  end

  assign inst_wr_en     = wr_en_q[NS_INST];
  assign data_wr_en     = wr_en_q[NS_DATA];
  assign weight_wr_en   = wr_en_q[NS_WEIGHT];
  assign meta_wr_en     = wr_en_q[NS_META];
  assign inst_wr_addr   = inst_addr_q;
  assign data_wr_addr   = data_addr_q;
  assign weight_wr_addr = weight_addr_q;
  assign meta_wr_addr   = meta_addr_q;
  assign wr_data        = wr_data_q;
  assign loading        = (state_q == ST_LOAD);
  assign running        = (state_q == ST_RUN);
  assign err_wr_in_run  = err_run_q;
  assign err_overflow   = err_ovf_q;

endmodule : pe_mem_wr_ctrl

// File: tb/tb_pe_mem_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_mem_wr_ctrl
// Directed bench for pe_mem_wr_ctrl. Two instances share the input bus:
// u_dut (peId=2, default widths) and u_ovf (peId=2, instAddrLen=2) used for
// the namespace-full behaviour, whose expectation follows
// PE_MEM_OVF_DETECT_EN.
// ---------------------------------------------------------------------------
module tb_pe_mem_wr_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        eoc = 1'b0;
  logic        mem_wrt_valid = 1'b0;
  logic [1:0]  peId_mem_in = '0;
  logic [1:0]  mem_data_type = '0;
  logic [15:0] mem_data_input = '0;

  logic        inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en;
  logic [7:0]  inst_wr_addr, data_wr_addr, weight_wr_addr, meta_wr_addr;
  logic [15:0] wr_data;
  logic        loading, running, err_wr_in_run, err_overflow;

  logic        o_inst_wr_en, o_data_wr_en, o_weight_wr_en, o_meta_wr_en;
  logic [1:0]  o_inst_wr_addr;
  logic [7:0]  o_data_wr_addr, o_weight_wr_addr, o_meta_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_loading, o_running, o_err_wr_in_run, o_err_overflow;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pe_mem_wr_ctrl #(.peId(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .eoc(eoc),
    .mem_wrt_valid(mem_wrt_valid), .peId_mem_in(peId_mem_in),
    .mem_data_type(mem_data_type), .mem_data_input(mem_data_input),
    .inst_wr_en(inst_wr_en), .data_wr_en(data_wr_en),
    .weight_wr_en(weight_wr_en), .meta_wr_en(meta_wr_en),
    .inst_wr_addr(inst_wr_addr), .data_wr_addr(data_wr_addr),
    .weight_wr_addr(weight_wr_addr), .meta_wr_addr(meta_wr_addr),
    .wr_data(wr_data), .loading(loading), .running(running),
    .err_wr_in_run(err_wr_in_run), .err_overflow(err_overflow)
  );

  pe_mem_wr_ctrl #(.peId(2), .instAddrLen(2)) u_ovf (
    .clk(clk), .reset(reset), .start(start), .eoc(eoc),
    .mem_wrt_valid(mem_wrt_valid), .peId_mem_in(peId_mem_in),
    .mem_data_type(mem_data_type), .mem_data_input(mem_data_input),
    .inst_wr_en(o_inst_wr_en), .data_wr_en(o_data_wr_en),
    .weight_wr_en(o_weight_wr_en), .meta_wr_en(o_meta_wr_en),
    .inst_wr_addr(o_inst_wr_addr), .data_wr_addr(o_data_wr_addr),
    .weight_wr_addr(o_weight_wr_addr), .meta_wr_addr(o_meta_wr_addr),
    .wr_data(o_wr_data), .loading(o_loading), .running(o_running),
    .err_wr_in_run(o_err_wr_in_run), .err_overflow(o_err_overflow)
  );

  // One bus cycle: drive at negedge, let the posedge sample it, then return
  // 1 time unit after that edge with the inputs released.
  task automatic step(input logic v, input logic [1:0] lane, input logic [1:0] typ,
                      input logic [15:0] data, input logic st, input logic ec);
    @(negedge clk);
    mem_wrt_valid  = v;
    peId_mem_in    = lane;
    mem_data_type  = typ;
    mem_data_input = data;
    start          = st;
    eoc            = ec;
    @(posedge clk);
    #1;
    mem_wrt_valid = 1'b0;
    start         = 1'b0;
    eoc           = 1'b0;
    $display("[TB] t=%0t v=%0b lane=%0d type=%0d data=%h start=%0b eoc=%0b -> en=%b waddr(i/d/w/m)=%0d/%0d/%0d/%0d wr_data=%h ld=%0b run=%0b err=%0b%0b",
             $time, v, lane, typ, data, st, ec,
             {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en},
             inst_wr_addr, data_wr_addr, weight_wr_addr, meta_wr_addr,
             wr_data, loading, running, err_wr_in_run, err_overflow);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en, loading, running,
         err_wr_in_run, err_overflow} !== 8'b0 ||
        {inst_wr_addr, data_wr_addr, weight_wr_addr, meta_wr_addr} !== 32'b0 ||
        wr_data !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: flags=%b addrs=%h wr_data=%h, required all 0",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en, loading, running,
                err_wr_in_run, err_overflow},
               {inst_wr_addr, data_wr_addr, weight_wr_addr, meta_wr_addr}, wr_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lane_mismatch();
    step(1'b1, 2'd1, 2'd0, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 2'd1, 2'd1, 16'h2222, 1'b0, 1'b0);
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en} !== 4'b0 ||
        loading !== 1'b0 || running !== 1'b0 || wr_data !== 16'h0) begin
      fails++;
      $display("FAIL lane_mismatch: en=%b ld=%b run=%b wr_data=%h, required en=0000 ld=0 run=0 wr_data=0000",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en}, loading, running, wr_data);
    end
  endtask

  task automatic test_basic_writes();
    step(1'b1, 2'd2, 2'd0, 16'h000A, 1'b0, 1'b0);
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en} !== 4'b1000 ||
        inst_wr_addr !== 8'd0 || wr_data !== 16'h000A || loading !== 1'b1) begin
      fails++;
      $display("FAIL write_inst0: en=%b addr=%0d data=%h ld=%b, required en=1000 addr=0 data=000a ld=1",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en}, inst_wr_addr, wr_data, loading);
    end
    step(1'b1, 2'd2, 2'd0, 16'h000B, 1'b0, 1'b0);
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en} !== 4'b1000 ||
        inst_wr_addr !== 8'd1 || wr_data !== 16'h000B) begin
      fails++;
      $display("FAIL write_inst1: en=%b addr=%0d data=%h, required en=1000 addr=1 data=000b",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en}, inst_wr_addr, wr_data);
    end
    step(1'b1, 2'd2, 2'd1, 16'h000C, 1'b0, 1'b0);
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en} !== 4'b0100 ||
        data_wr_addr !== 8'd0 || wr_data !== 16'h000C || inst_wr_addr !== 8'd1) begin
      fails++;
      $display("FAIL write_data0: en=%b daddr=%0d iaddr=%0d data=%h, required en=0100 daddr=0 iaddr=1 data=000c",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en}, data_wr_addr, inst_wr_addr, wr_data);
    end
    step(1'b0, 2'd2, 2'd0, 16'hFFFF, 1'b0, 1'b0);
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en} !== 4'b0 ||
        wr_data !== 16'h000C || loading !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold: en=%b data=%h ld=%b, required en=0000 data=000c ld=1",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en}, wr_data, loading);
    end
  endtask

  task automatic test_start_with_write();
    step(1'b1, 2'd2, 2'd2, 16'h0055, 1'b1, 1'b0);
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en} !== 4'b0010 ||
        weight_wr_addr !== 8'd0 || wr_data !== 16'h0055 ||
        running !== 1'b1 || loading !== 1'b0) begin
      fails++;
      $display("FAIL start_with_write: en=%b waddr=%0d data=%h run=%b ld=%b, required en=0010 waddr=0 data=0055 run=1 ld=0",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en}, weight_wr_addr, wr_data, running, loading);
    end
    step(1'b1, 2'd2, 2'd0, 16'h0066, 1'b0, 1'b0);
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en} !== 4'b0 ||
        err_wr_in_run !== 1'b1 || wr_data !== 16'h0055 || running !== 1'b1) begin
      fails++;
      $display("FAIL write_in_run: en=%b err=%b data=%h run=%b, required en=0000 err=1 data=0055 run=1",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en}, err_wr_in_run, wr_data, running);
    end
    step(1'b0, 2'd0, 2'd0, 16'h0, 1'b1, 1'b0);
    tests_run++;
    if (running !== 1'b1 || err_wr_in_run !== 1'b1) begin
      fails++;
      $display("FAIL start_in_run: run=%b err=%b, required run=1 err=1", running, err_wr_in_run);
    end
  endtask

  task automatic test_start_eoc();
    step(1'b0, 2'd0, 2'd0, 16'h0, 1'b1, 1'b1);
    tests_run++;
    if (running !== 1'b0 || loading !== 1'b0 || err_wr_in_run !== 1'b0) begin
      fails++;
      $display("FAIL start_eoc: run=%b ld=%b err=%b, required run=0 ld=0 err=0",
               running, loading, err_wr_in_run);
    end
    step(1'b1, 2'd2, 2'd0, 16'h0077, 1'b0, 1'b0);
    tests_run++;
    if (inst_wr_en !== 1'b1 || inst_wr_addr !== 8'd0 || wr_data !== 16'h0077 ||
        loading !== 1'b1 || err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL write_after_eoc: en=%b addr=%0d data=%h ld=%b ovf=%b, required en=1 addr=0 data=0077 ld=1 ovf=0",
               inst_wr_en, inst_wr_addr, wr_data, loading, err_overflow);
    end
  endtask

  task automatic test_reset_mid_load();
    step(1'b1, 2'd2, 2'd1, 16'h0101, 1'b0, 1'b0);
    step(1'b1, 2'd2, 2'd1, 16'h0102, 1'b0, 1'b0);
    step(1'b1, 2'd2, 2'd1, 16'h0103, 1'b0, 1'b0);
    tests_run++;
    if (data_wr_en !== 1'b1 || data_wr_addr !== 8'd2 || wr_data !== 16'h0103) begin
      fails++;
      $display("FAIL data_third: en=%b addr=%0d data=%h, required en=1 addr=2 data=0103",
               data_wr_en, data_wr_addr, wr_data);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en, loading, running,
         err_wr_in_run, err_overflow} !== 8'b0 ||
        {inst_wr_addr, data_wr_addr, weight_wr_addr, meta_wr_addr} !== 32'b0 ||
        wr_data !== 16'h0) begin
      fails++;
      $display("FAIL async_reset: flags=%b addrs=%h wr_data=%h, required all 0",
               {inst_wr_en, data_wr_en, weight_wr_en, meta_wr_en, loading, running,
                err_wr_in_run, err_overflow},
               {inst_wr_addr, data_wr_addr, weight_wr_addr, meta_wr_addr}, wr_data);
    end
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 2'd2, 2'd1, 16'h0200, 1'b0, 1'b0);
    tests_run++;
    if (data_wr_en !== 1'b1 || data_wr_addr !== 8'd0 || wr_data !== 16'h0200) begin
      fails++;
      $display("FAIL write_after_reset: en=%b addr=%0d data=%h, required en=1 addr=0 data=0200",
               data_wr_en, data_wr_addr, wr_data);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_addr [5];
    logic       exp_en   [5];
    logic       exp_ovf;
`ifdef PE_MEM_OVF_DETECT_EN
    exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_en   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_ovf  = 1'b1;
`else
    exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_en   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_ovf  = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd2, 2'd0, 16'h0300 + 16'(i), 1'b0, 1'b0);
      tests_run++;
      if (o_inst_wr_en !== exp_en[i] || o_inst_wr_addr !== exp_addr[i]) begin
        fails++;
        $display("FAIL ovf_write%0d: en=%b addr=%0d, required en=%b addr=%0d",
                 i, o_inst_wr_en, o_inst_wr_addr, exp_en[i], exp_addr[i]);
      end
    end
    tests_run++;
    if (o_err_overflow !== exp_ovf || err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_flag: small=%b wide=%b, required small=%b wide=0",
               o_err_overflow, err_overflow, exp_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_lane_mismatch();
    test_basic_writes();
    test_start_with_write();
    test_start_eoc();
    test_reset_mid_load();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule : tb_pe_mem_wr_ctrl
